tlc_intersection_ctrl: RTL and testbench
========================================

# tlc_intersection_ctrl

Parametrised two-road traffic-light controller: the next generation of the single-signal red/yellow/green control unit. It drives a north-south (NS) and an east-west (EW) signal head and inserts an all-red clearance interval between conflicting greens. It has an integrated tick-enabled phase timer, so no external datapath counter is needed. An optional pedestrian walk phase can be compiled in. It sits between the 1 Hz (or other) tick prescaler and the lamp drivers.

## Interface
- T_GREEN, 30: green duration in ticks (≥1)
- T_YEL, 5: yellow duration in ticks (≥1)
- T_ALLRED, 2: all-red clearance duration in ticks (≥1)
- T_WALK, 10: pedestrian walk duration in ticks (≥1); used only with the walk feature
- CNT_W, 6: timer width; must hold max(T_*)−1
- clk  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-cycle timebase enable pulse
- ped_req  in  1  pedestrian button, level or pulse, sampled every cycle
- ns_lights  out  3  {red, yel, green} for NS
- ew_lights  out  3  {red, yel, green} for EW
- walk  out  1  pedestrian walk lamp
- ped_pending  out  1  latched, unserved pedestrian request
- phase_remaining  out  CNT_W  ticks left in current phase minus one

## Operation
- States: ALLRED_A (precedes NS_GREEN), NS_GREEN, NS_YEL, ALLRED_B (precedes EW_GREEN), EW_GREEN, EW_YEL, WALK (walk build only).
- Base cycle: ALLRED_A → NS_GREEN → NS_YEL → ALLRED_B → EW_GREEN → EW_YEL → ALLRED_A.
- Timer: on entry to a phase of duration T, load T−1. On each tick with count>0, decrement. On a tick with count==0, advance the state. A phase therefore spans exactly T tick pulses. When tick=0, nothing changes.
- Lamp decode (Moore, from the state register only):
  - NS_GREEN: ns=001, ew=100
  - NS_YEL: ns=010, ew=100
  - EW_GREEN: ns=100, ew=001
  - EW_YEL: ns=100, ew=010
  - ALLRED_*/WALK: ns=ew=100
- Exactly one of red/yel/green is set per head, in every state.
- walk=1 only in WALK.
- Reset (next edge): state=ALLRED_A, phase_remaining=T_ALLRED−1, ns_lights=ew_lights=100, walk=0, ped_pending=0. This applies identically when reset is asserted mid-phase.
- Pedestrian (walk build):
  - ped_req=1 sets ped_pending.
  - When an ALLRED_* phase expires with ped_pending=1, go to WALK (load T_WALK−1) instead of the green, then continue to the green that ALLRED would have entered. A one-bit next-direction register holds that choice.
  - ped_pending clears on the edge that enters WALK. A ped_req in that same cycle is absorbed and does not re-set the latch.
  - ped_req is ignored while in WALK.
  - A request during a green is served at the next ALLRED expiry; greens are never shortened.
- Illegal state encoding: recover to ALLRED_A on the next edge.

## Timing
- Outputs are registered-state decodes: lamps change on the clock edge following the expiring tick.
- One-cycle latency from ped_req to ped_pending.
- Full period without walks: 2·(T_GREEN+T_YEL+T_ALLRED) ticks.
- reset has priority over tick and ped_req in the same cycle.

## Configuration
- TLC_PED_WALK_EN defined: the WALK state, the pending latch and the next-direction register are built; behaviour is as above.
- Not defined: there is no WALK state, walk and ped_pending are tied to 0, ped_req is ignored, and T_WALK is unused.

## Structure
- Package traffic_light_pkg holds:
  - the state enum typedef
  - the 3-bit lamp constants LAMP_RED=100, LAMP_YEL=010, LAMP_GRN=001
- One sub-module, tlc_phase_timer: a loadable CNT_W down-counter with tick enable, a load port and a zero flag.
- The FSM and decode live in the top module.

## Test plan
(T_GREEN=3, T_YEL=2, T_ALLRED=1, T_WALK=2, tick=1 every cycle unless stated)
- Reset, then free run with no ped_req → states ALLRED_A(1), NS_GREEN(3), NS_YEL(2), ALLRED_B(1), EW_GREEN(3), EW_YEL(2), repeating with a 12-cycle period; lamp codes as decoded.
- tick every 4th cycle → every phase lasts 4×T cycles; state and phase_remaining are frozen between ticks.
- One-cycle ped_req in NS_GREEN → ped_pending=1 next cycle; after NS_YEL and ALLRED_B comes WALK for 2 ticks with walk=1 and all heads 100; then EW_GREEN; ped_pending=0 from WALK entry.
- ped_req held high across WALK entry and throughout WALK → exactly one WALK; ped_pending=0 after entry; held ped_req re-latches after WALK exits.
- Assert reset for one cycle mid-EW_GREEN → next edge gives ALLRED_A, phase_remaining=0, lamps 100/100, ped_pending=0.
- Build without TLC_PED_WALK_EN, ped_req toggling → sequence identical to the first scenario; walk=0 and ped_pending=0 throughout.

Source files
------------

// File: rtl/traffic_light_pkg.sv
// Shared types for the two-road intersection controller.
// State encoding and the one-hot {red, yel, green} lamp codes.
package traffic_light_pkg;

    typedef enum logic [2:0] {
        ALLRED_A = 3'd0,
        NS_GREEN = 3'd1,
        NS_YEL   = 3'd2,
        ALLRED_B = 3'd3,
        EW_GREEN = 3'd4,
        EW_YEL   = 3'd5,
        WALK     = 3'd6
    } tlc_state_e;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

endpackage

// File: rtl/tlc_phase_timer.sv
// Loadable down-counter for phase timing.
// Decrements once per tick, holds at zero; load wins over tick.
module tlc_phase_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    assign zero = (count == '0);

    always_ff @(posedge clk) begin
        if (load) begin
            count <= load_val;
        end else if (tick && !zero) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/tlc_intersection_ctrl.sv
// Two-road traffic-light controller with all-red clearance.
// Optional pedestrian walk phase built when TLC_PED_WALK_EN is defined.
module tlc_intersection_ctrl
    import traffic_light_pkg::*;
#(
    parameter int T_GREEN  = 30,
    parameter int T_YEL    = 5,
    parameter int T_ALLRED = 2,
    parameter int T_WALK   = 10,
    parameter int CNT_W    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             ped_req,
    output logic [2:0]       ns_lights,
    output logic [2:0]       ew_lights,
    output logic             walk,
    output logic             ped_pending,
    output logic [CNT_W-1:0] phase_remaining
);

`ifdef TLC_PED_WALK_EN
    localparam bit WALK_EN = 1'b1;
`else
    localparam bit WALK_EN = 1'b0;
`endif

    tlc_state_e       state;
    tlc_state_e       nxt;
    logic             adv;
    logic             zero;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             ped_q;
    logic             dir_q;
    logic             walk_q;
    logic             walk_go;

    function automatic logic [CNT_W-1:0] dur(input tlc_state_e s);
        case (s)
            NS_GREEN, EW_GREEN: dur = CNT_W'(T_GREEN - 1);
            NS_YEL, EW_YEL:     dur = CNT_W'(T_YEL - 1);
            WALK:               dur = CNT_W'(T_WALK - 1);
            default:            dur = CNT_W'(T_ALLRED - 1);
        endcase
    endfunction

    function automatic logic [2:0] ns_dec(input tlc_state_e s);
        case (s)
            NS_GREEN: ns_dec = LAMP_GRN;
            NS_YEL:   ns_dec = LAMP_YEL;
            default:  ns_dec = LAMP_RED;
        endcase
    endfunction

    function automatic logic [2:0] ew_dec(input tlc_state_e s);
        case (s)
            EW_GREEN: ew_dec = LAMP_GRN;
            EW_YEL:   ew_dec = LAMP_YEL;
            default:  ew_dec = LAMP_RED;
        endcase
    endfunction

    assign adv     = tick & zero;
    assign walk_go = WALK_EN & ped_q;

    always_comb begin
        nxt = state;
        case (state)
            ALLRED_A: if (adv) nxt = walk_go ? WALK : NS_GREEN;
            NS_GREEN: if (adv) nxt = NS_YEL;
            NS_YEL:   if (adv) nxt = ALLRED_B;
            ALLRED_B: if (adv) nxt = walk_go ? WALK : EW_GREEN;
            EW_GREEN: if (adv) nxt = EW_YEL;
            EW_YEL:   if (adv) nxt = ALLRED_A;
            WALK: begin
                if (!WALK_EN) begin
                    nxt = ALLRED_A;
                end else if (adv) begin
                    if (dir_q) nxt = EW_GREEN;
                    else       nxt = NS_GREEN;
                end
            end
            default:  nxt = ALLRED_A;
        endcase
    end

    // Every state change reloads; reset reloads even when already in ALLRED_A.
    assign load     = reset | (nxt != state);
    assign load_val = reset ? CNT_W'(T_ALLRED - 1) : dur(nxt);

    tlc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .load     (load),
        .load_val (load_val),
        .tick     (tick),
        .count    (phase_remaining),
        .zero     (zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ALLRED_A;
            ns_lights <= LAMP_RED;
            ew_lights <= LAMP_RED;
            walk_q    <= 1'b0;
        end else begin
            state     <= nxt;
            ns_lights <= ns_dec(nxt);
            ew_lights <= ew_dec(nxt);
            walk_q    <= (nxt == WALK);
        end
    end

`ifdef TLC_PED_WALK_EN
    // dir_q remembers which green the interrupted ALLRED was heading to.
    always_ff @(posedge clk) begin
        if (reset) begin
            ped_q <= 1'b0;
            dir_q <= 1'b0;
        end else if (nxt == WALK && state != WALK) begin
            ped_q <= 1'b0;
            dir_q <= (state == ALLRED_B);
        end else if (state != WALK && ped_req) begin
            ped_q <= 1'b1;
        end
    end
`else
    logic unused_ped;
    assign ped_q      = 1'b0;
    assign dir_q      = 1'b0;
    assign unused_ped = ped_req;
`endif

    assign walk        = walk_q;
    assign ped_pending = ped_q;

endmodule

// File: tb/tb_tlc_intersection_ctrl.sv
// Randomised bench for tlc_intersection_ctrl against a tick-counting model.
// Works in both builds (TLC_PED_WALK_EN defined or not).
module tb_tlc_intersection_ctrl;

    localparam int TG = 3;
    localparam int TY = 2;
    localparam int TA = 1;
    localparam int TW = 2;
    localparam int CW = 6;

`ifdef TLC_PED_WALK_EN
    localparam bit WALK_EN = 1'b1;
`else
    localparam bit WALK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tick = 1'b0;
    logic          ped_req = 1'b0;
    logic [2:0]    ns_lights;
    logic [2:0]    ew_lights;
    logic          walk;
    logic          ped_pending;
    logic [CW-1:0] phase_remaining;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    tlc_intersection_ctrl #(
        .T_GREEN  (TG),
        .T_YEL    (TY),
        .T_ALLRED (TA),
        .T_WALK   (TW),
        .CNT_W    (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .tick            (tick),
        .ped_req         (ped_req),
        .ns_lights       (ns_lights),
        .ew_lights       (ew_lights),
        .walk            (walk),
        .ped_pending     (ped_pending),
        .phase_remaining (phase_remaining)
    );

    always #5 clk = ~clk;

    // Phases 0..5: base cycle from ALLRED_A; phase 6: walk.
    int         dur_tab [7] = '{TA, TG, TY, TA, TG, TY, TW};
    logic [2:0] ns_tab  [7] = '{3'b100, 3'b001, 3'b010, 3'b100,
                                3'b100, 3'b100, 3'b100};
    logic [2:0] ew_tab  [7] = '{3'b100, 3'b100, 3'b100, 3'b100,
                                3'b001, 3'b010, 3'b100};

    int m_ph    = 0;
    int m_rem   = TA;
    int m_after = 1;
    bit m_pend  = 1'b0;

    function automatic void model_step(input bit rs, input bit tk,
                                       input bit pr);
        int  old_ph;
        bit  entered;
        old_ph  = m_ph;
        entered = 1'b0;
        if (rs) begin
            m_ph   = 0;
            m_rem  = TA;
            m_pend = 1'b0;
            return;
        end
        if (tk) begin
            if (m_rem > 1) begin
                m_rem--;
            end else begin
                if ((m_ph == 0 || m_ph == 3) && WALK_EN && m_pend) begin
                    m_after = m_ph + 1;
                    m_ph    = 6;
                    m_pend  = 1'b0;
                    entered = 1'b1;
                end else if (m_ph == 6) begin
                    m_ph = m_after;
                end else begin
                    m_ph = (m_ph + 1) % 6;
                end
                m_rem = dur_tab[m_ph];
            end
        end
        if (WALK_EN && !entered && old_ph != 6 && pr) m_pend = 1'b1;
    endfunction

    function automatic logic [13:0] obs();
        return {ns_lights, ew_lights, walk, ped_pending, phase_remaining};
    endfunction

    function automatic logic [13:0] expv();
        return {ns_tab[m_ph], ew_tab[m_ph], (m_ph == 6), m_pend,
                CW'(m_rem - 1)};
    endfunction

    task automatic drive(input bit rs, input bit tk, input bit pr);
        @(negedge clk);
        reset   = rs;
        tick    = tk;
        ped_req = pr;
        @(posedge clk);
        model_step(rs, tk, pr);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1);
        checks++;
        if (obs() !== expv()) begin
            fails++;
            $display("FAIL reset cyc=%0d got=%b want=%b", cyc, obs(), expv());
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (obs() !== 14'b100_100_0_0_000000) begin
            fails++;
            $display("FAIL reset_hold cyc=%0d got=%b want=%b",
                     cyc, obs(), 14'b100_100_0_0_000000);
        end
    endtask

    task automatic test_free_run();
        int ng_first;
        int ng_second;
        ng_first  = -1;
        ng_second = -1;
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            checks++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL free_run cyc=%0d got=%b want=%b",
                         cyc, obs(), expv());
            end
            if (ns_lights == 3'b001 && phase_remaining == CW'(TG - 1)) begin
                if (ng_first < 0) ng_first = i;
                else if (ng_second < 0) ng_second = i;
            end
        end
        checks++;
        if (ng_second - ng_first !== 2 * (TG + TY + TA)) begin
            fails++;
            $display("FAIL period got=%0d want=%0d",
                     ng_second - ng_first, 2 * (TG + TY + TA));
        end
    endtask

    task automatic test_slow_tick();
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            drive(1'b0, (i % 4) == 3, 1'b0);
            checks++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL slow_tick cyc=%0d got=%b want=%b",
                         cyc, obs(), expv());
            end
        end
    endtask

    task automatic test_ped_pulse();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        checks++;
        if (ped_pending !== WALK_EN) begin
            fails++;
            $display("FAIL ped_latch got=%b want=%b", ped_pending, WALK_EN);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            checks++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL ped_pulse cyc=%0d got=%b want=%b",
                         cyc, obs(), expv());
            end
        end
    endtask

    task automatic test_ped_held();
        int walks;
        bit prev;
        walks = 0;
        prev  = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, 1'b1);
            checks++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL ped_held cyc=%0d got=%b want=%b",
                         cyc, obs(), expv());
            end
            if (walk && !prev) walks++;
            prev = walk;
        end
        checks++;
        if (walks !== (WALK_EN ? 1 : 0)) begin
            fails++;
            $display("FAIL walk_count got=%0d want=%0d",
                     walks, WALK_EN ? 1 : 0);
        end
    endtask

    task automatic test_mid_reset();
        int budget;
        budget = 0;
        drive(1'b1, 1'b0, 1'b0);
        while (!(m_ph == 4 && m_rem == TG - 1) && budget < 50) begin
            drive(1'b0, 1'b1, 1'b0);
            budget++;
        end
        checks++;
        if (budget >= 50) begin
            fails++;
            $display("FAIL mid_reset_reach got=%0d want=<50", budget);
        end
        drive(1'b1, 1'b1, 1'b1);
        checks++;
        if (obs() !== 14'b100_100_0_0_000000) begin
            fails++;
            $display("FAIL mid_reset cyc=%0d got=%b want=%b",
                     cyc, obs(), 14'b100_100_0_0_000000);
        end
    endtask

    task automatic test_random();
        bit rs;
        bit tk;
        bit pr;
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            rs = ($urandom_range(0, 79) == 0);
            tk = ($urandom_range(0, 2) != 0);
            pr = ($urandom_range(0, 9) == 0);
            drive(rs, tk, pr);
            checks++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL random cyc=%0d got=%b want=%b",
                         cyc, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_slow_tick();
        test_ped_pulse();
        test_ped_held();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
